input_packet_buffer: RTL and testbench

INPUT_PACKET_BUFFER -- requirements
Module: input_packet_buffer

---
 rtl/input_packet_buffer.sv | 147 ++++++++++++++
 tb/tb_input_packet_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/input_packet_buffer.sv
// Input packet buffer between the host and the grid's west-edge input port.
// The host writes packets and end-of-tick markers into a circular FIFO. Release
// toward the grid is gated by tick credits. Each credit opens the FIFO until
// the next marker, and that marker is then consumed internally.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   tick             one-cycle pulse at the start of a network tick (adds a credit)
//   wen, wdata       host packet write
//   weot             host end-of-tick marker write
//   ren              pop request from the grid
//   packet_out       head payload (zero when empty)
//   empty            no packet releasable to the grid
//   full, count      occupancy (markers included)
//   overflow_error, underflow_error, protocol_error   sticky error flags
module input_packet_buffer #(
   parameter int unsigned PACKET_WIDTH = 30,
   parameter int unsigned DEPTH        = 512,
   parameter int unsigned CREDIT_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     wen,
   input  logic [PACKET_WIDTH-1:0]  wdata,
   input  logic                     weot,
   input  logic                     ren,
   output logic [PACKET_WIDTH-1:0]  packet_out,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_error,
   output logic                     underflow_error,
   output logic                     protocol_error
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] CreditMax = '1;

   typedef enum logic [0:0] {StWait, StOpen} state_e;

   state_e                  state_q, state_d;
   logic [PACKET_WIDTH:0]   mem [DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [AW:0]             count_q, count_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic                    ovf_q, udf_q, prot_q;

   logic [PACKET_WIDTH:0]   head;
   logic                    head_valid, head_marker;
   logic                    full_int, wr_any, wr_both, wr_accept;
   logic                    release_pkt, pop, credit_dec, tick_sat;

   assign head        = mem[rd_ptr_q];
   assign head_valid  = (count_q != '0);
   assign head_marker = head[PACKET_WIDTH];
   assign full_int    = (count_q == (AW+1)'(DEPTH));
   assign wr_any      = wen | weot;
   assign wr_both     = wen & weot;
   assign wr_accept   = (wen ^ weot) & ~full_int;
   // A tick coinciding with a decrement is absorbed, so it cannot saturate.
   assign tick_sat    = tick & (credits_q == CreditMax) & ~credit_dec;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StWait;
      else      state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWait: if (credits_q != '0) state_d = StOpen;
         StOpen: if (head_valid && head_marker) state_d = StWait;
         default: state_d = StWait;
      endcase
   end

   // FSM outputs
   always_comb begin
      release_pkt = 1'b0;
      pop         = 1'b0;
      credit_dec  = 1'b0;
      unique case (state_q)
         StWait: credit_dec = (credits_q != '0);
         StOpen: begin
            if (head_valid) begin
               if (head_marker) begin
                  pop = 1'b1;  // marker retires internally, never shown to the grid
               end else begin
                  release_pkt = 1'b1;
                  pop         = ren;
               end
            end
         end
         default: ;
      endcase
   end

   assign empty      = ~release_pkt;
   assign packet_out = release_pkt ? head[PACKET_WIDTH-1:0] : '0;
   assign full       = full_int;
   assign count      = count_q;
   assign overflow_error  = ovf_q;
   assign underflow_error = udf_q;
   assign protocol_error  = prot_q;

   always_comb begin
      credits_d = credits_q;
      if (tick && !credit_dec) begin
         if (credits_q != CreditMax) credits_d = credits_q + 1'b1;
      end else if (credit_dec && !tick) begin
         credits_d = credits_q - 1'b1;
      end
   end

   assign count_d = count_q + (AW+1)'(wr_accept) - (AW+1)'(pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         credits_q <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         prot_q    <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         credits_q <= credits_d;
         if (wr_any && full_int) ovf_q  <= 1'b1;
         if (ren && empty)       udf_q  <= 1'b1;
         if (wr_both || tick_sat) prot_q <= 1'b1;
      end
   end

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= weot ? {1'b1, {PACKET_WIDTH{1'b0}}} : {1'b0, wdata};
      end
   end

endmodule

// File: tb/tb_input_packet_buffer.sv
module tb_input_packet_buffer;

   localparam int PW    = 30;
   localparam int DEPTH = 512;
   localparam int CMAX  = 15;

   logic          clk, rst, tick, wen, weot, ren;
   logic [PW-1:0] wdata, packet_out;
   logic          empty, full, overflow_error, underflow_error, protocol_error;
   logic [9:0]    count;

   input_packet_buffer #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .CREDIT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .tick(tick), .wen(wen), .wdata(wdata), .weot(weot),
      .ren(ren), .packet_out(packet_out), .empty(empty), .full(full), .count(count),
      .overflow_error(overflow_error), .underflow_error(underflow_error),
      .protocol_error(protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: entry queue, credit integer, release-open flag.
   logic [PW:0] mq[$];
   int          m_cred;
   bit          m_open, m_ovf, m_udf, m_prot;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cred = 0; m_open = 0; m_ovf = 0; m_udf = 0; m_prot = 0;
   endtask

   function automatic bit model_empty();
      return !(m_open && mq.size() > 0 && !mq[0][PW]);
   endfunction

   task automatic model_step(input bit t, input bit w, input bit e, input bit r,
                             input logic [PW-1:0] d);
      bit me, pop_m, pop_marker, dec;
      int pre;
      me         = model_empty();
      pop_m      = m_open && mq.size() > 0 && (mq[0][PW] || r);
      pop_marker = pop_m && mq[0][PW];
      dec        = !m_open && m_cred > 0;
      pre        = mq.size();
      if (r && me) m_udf = 1;
      if (w && e) m_prot = 1;
      if ((w || e) && pre == DEPTH) m_ovf = 1;
      if (pop_m) void'(mq.pop_front());
      if ((w ^ e) && pre < DEPTH) mq.push_back(e ? {1'b1, {PW{1'b0}}} : {1'b0, d});
      if (t && !dec) begin
         if (m_cred == CMAX) m_prot = 1;
         else m_cred++;
      end
      if (dec && !t) m_cred--;
      if (!m_open) m_open = dec;
      else if (pop_marker) m_open = 0;
   endtask

   task automatic compare_all();
      bit me;
      logic [PW-1:0] xp;
      me = model_empty();
      xp = me ? '0 : mq[0][PW-1:0];
      chk("empty", empty, me);
      chk("packet_out", packet_out, xp);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("overflow_error", overflow_error, m_ovf);
      chk("underflow_error", underflow_error, m_udf);
      chk("protocol_error", protocol_error, m_prot);
      chk("credits", dut.credits_q, m_cred);
   endtask

   // Called at a falling edge; applies inputs across one rising edge.
   task automatic cycle(input bit t, input bit w, input bit e, input bit r,
                        input logic [PW-1:0] d);
      tick = t; wen = w; weot = e; ren = r; wdata = d;
      @(posedge clk);
      model_step(t, w, e, r, d);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      tick = 0; wen = 0; weot = 0; ren = 0; wdata = '0;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      compare_all();
   endtask

   typedef struct {
      bit            t, w, e, r;
      logic [PW-1:0] d;
      bit            x_empty;
      int            x_count;
      logic [PW-1:0] x_pkt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // Packets 1, 2, marker; tick; drain with ren.
      tbl[0] = '{0, 1, 0, 0, 30'h1, 1, 1, 30'h0};
      tbl[1] = '{0, 1, 0, 0, 30'h2, 1, 2, 30'h0};
      tbl[2] = '{0, 0, 1, 0, 30'h0, 1, 3, 30'h0};
      tbl[3] = '{0, 0, 0, 0, 30'h0, 1, 3, 30'h0};
      tbl[4] = '{1, 0, 0, 0, 30'h0, 1, 3, 30'h0};
      tbl[5] = '{0, 0, 0, 0, 30'h0, 0, 3, 30'h1};
      tbl[6] = '{0, 0, 0, 1, 30'h0, 0, 2, 30'h2};
      tbl[7] = '{0, 0, 0, 1, 30'h0, 1, 1, 30'h0};
      tbl[8] = '{0, 0, 0, 0, 30'h0, 1, 0, 30'h0};
      tbl[9] = '{0, 1, 0, 0, 30'h7, 1, 1, 30'h0};

      rst = 1'b0; tick = 0; wen = 0; weot = 0; ren = 0; wdata = '0;
      model_reset();
      @(negedge clk);
      chk("reset_empty", empty, 1);
      chk("reset_count", count, 0);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].t, tbl[i].w, tbl[i].e, tbl[i].r, tbl[i].d);
         chk($sformatf("tbl%0d_empty", i), empty, tbl[i].x_empty);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].x_count);
         chk($sformatf("tbl%0d_pkt", i), packet_out, tbl[i].x_pkt);
      end
      chk("tbl_credits", dut.credits_q, 0);

      // Underflow then simultaneous wen/weot.
      do_reset();
      cycle(0, 0, 0, 1, '0);
      chk("underflow_set", underflow_error, 1);
      chk("underflow_count", count, 0);
      cycle(0, 1, 1, 0, 30'h5);
      chk("proto_both", protocol_error, 1);
      chk("proto_nothing_stored", count, 0);

      // Fill, then write while popping.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, PW'(i + 1));
      chk("fill_full", full, 1);
      chk("fill_count", count, DEPTH);
      cycle(1, 0, 0, 0, '0);
      cycle(0, 0, 0, 0, '0);
      chk("fill_open", empty, 0);
      chk("fill_head", packet_out, 1);
      cycle(0, 1, 0, 1, 30'h3ff_ffff);
      chk("ovf_count", count, DEPTH - 1);
      chk("ovf_flag", overflow_error, 1);
      chk("ovf_head", packet_out, 2);

      // Credit saturation, then markers consumed one per credit.
      do_reset();
      for (int i = 0; i < 17; i++) cycle(1, 0, 0, 0, '0);
      chk("sat_credits", dut.credits_q, CMAX);
      chk("sat_proto", protocol_error, 1);
      for (int m = 0; m < 3; m++) begin
         cycle(0, 0, 1, 0, '0);
         cycle(0, 0, 0, 0, '0);
         cycle(0, 0, 0, 0, '0);
         chk($sformatf("marker%0d_credits", m), dut.credits_q, CMAX - 1 - m);
         chk($sformatf("marker%0d_count", m), count, 0);
      end

      // Reset mid-release takes effect without a clock edge.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, PW'(30'h100 + i));
      chk("mid_count", count, 5);
      chk("mid_open", empty, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_empty", empty, 1);
      chk("async_count", count, 0);
      chk("async_credits", dut.credits_q, 0);
      chk("async_pkt", packet_out, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      compare_all();

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, PW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
